// File: rtl/n64_vinfo_ext_v2_pkg.sv
// Shared constants and types for the N64 video-info extractor.
// Holds vinfo/sync bit positions, line thresholds and the mode bundle.
package n64_vinfo_ext_v2_pkg;

  localparam int VINFO_VDATA = 3;
  localparam int VINFO_PAL   = 1;
  localparam int VINFO_480I  = 0;

  localparam int SYNC_V = 3;
  localparam int SYNC_H = 1;
  localparam int SYNC_C = 0;

  localparam int DEF_PAL_LINES = 288;
  localparam int DEF_MIN_LINES = 200;

  typedef struct packed {
    logic pal;
    logic i480;
  } mode_t;

  localparam mode_t MODE_RST = '{pal: 1'b0, i480: 1'b1};

endpackage

// File: rtl/n64_sync_timeout.sv
// Saturating sync-watchdog counter with timeout flag.
// Timeout is either the MSB or the all-ones value, chosen by MSB_TO.
module n64_sync_timeout #(
  parameter int   W      = 8,
  parameter logic MSB_TO = 1'b0
) (
  input  logic VCLK,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic to
);

  logic [W-1:0] cnt;

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign to = MSB_TO ? cnt[W-1] : &cnt;

endmodule

// File: rtl/n64_vinfo_ext_v2.sv
// N64 video-info extractor: vdata presence, PAL/NTSC and 240p/480i.
// Optional mode debounce selected by VINFO_MODE_DEBOUNCE_EN.
module n64_vinfo_ext_v2
  import n64_vinfo_ext_v2_pkg::*;
#(
  parameter int DS_TO_W     = 3,
  parameter int V_TO_W      = 9,
  parameter int H_TO_W      = 10,
  parameter int C_TO_W      = 11,
  parameter int LCNT_W      = 10,
  parameter int PAL_LINES   = DEF_PAL_LINES,
  parameter int MIN_LINES   = DEF_MIN_LINES,
  parameter int STABLE_FLDS = 3
) (
  input  logic              VCLK,
  input  logic              nRST,
  input  logic              nVDSYNC,
  input  logic [3:0]        Sync_pre,
  input  logic [3:0]        Sync_cur,
  output logic [3:0]        vinfo_o,
  output logic [LCNT_W-1:0] lines_o,
  output logic              mode_chg_o
);

  localparam logic [LCNT_W-1:0] PAL_L = LCNT_W'(PAL_LINES);
  localparam logic [LCNT_W-1:0] MIN_L = LCNT_W'(MIN_LINES);

  logic smp, neg_v, neg_h, neg_c;
  logic to_ds, to_v, to_h, to_c;
  logic [3:0] flags;
  logic vdata, loss;
  logic [LCNT_W-1:0] lcnt;
  logic field_id, runt, eval, reach, commit, locked;
  mode_t cand, mode;
  logic unused_sync;

  assign smp   = ~nVDSYNC;
  assign neg_v = smp & Sync_pre[SYNC_V] & ~Sync_cur[SYNC_V];
  assign neg_h = smp & Sync_pre[SYNC_H] & ~Sync_cur[SYNC_H];
  assign neg_c = smp & Sync_pre[SYNC_C] & ~Sync_cur[SYNC_C];
  assign unused_sync = Sync_pre[2] ^ Sync_cur[2];

  n64_sync_timeout #(.W(DS_TO_W), .MSB_TO(1'b1)) u_ds (
    .VCLK(VCLK), .nRST(nRST),
    .clr(smp), .inc(nVDSYNC), .to(to_ds)
  );

  n64_sync_timeout #(.W(V_TO_W)) u_v (
    .VCLK(VCLK), .nRST(nRST),
    .clr(neg_v), .inc(neg_h), .to(to_v)
  );

  n64_sync_timeout #(.W(H_TO_W)) u_h (
    .VCLK(VCLK), .nRST(nRST),
    .clr(neg_h), .inc(smp), .to(to_h)
  );

  n64_sync_timeout #(.W(C_TO_W)) u_c (
    .VCLK(VCLK), .nRST(nRST),
    .clr(neg_c), .inc(smp), .to(to_c)
  );

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      flags <= '0;
      vdata <= 1'b0;
    end else begin
      flags <= ~{to_ds, to_v, to_h, to_c};
      vdata <= &flags;
    end
  end

  assign loss = vdata & ~(&flags);

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      lcnt <= '0;
    end else if (neg_v) begin
      lcnt <= '0;
    end else if (neg_h && lcnt != '1) begin
      lcnt <= lcnt + 1'b1;
    end
  end

  assign runt      = lcnt < MIN_L;
  assign eval      = neg_v & ~runt;
  assign cand.pal  = lcnt > PAL_L;
  assign cand.i480 = field_id ^ neg_h;

`ifdef VINFO_MODE_DEBOUNCE_EN
  localparam int SW = $clog2(STABLE_FLDS + 1);
  localparam logic [SW-1:0] STAB_L = SW'(STABLE_FLDS);

  logic [SW-1:0] stab, stab_nxt;
  mode_t prev;

  // stab == 0 means no previous candidate to agree with
  always_comb begin
    stab_nxt = SW'(1);
    if (stab != '0 && cand == prev) begin
      stab_nxt = (stab == STAB_L) ? stab : stab + 1'b1;
    end
  end

  assign reach = (stab_nxt == STAB_L);

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      stab <= '0;
      prev <= '0;
    end else if (loss || (neg_v && runt)) begin
      stab <= '0;
    end else if (eval) begin
      stab <= stab_nxt;
      prev <= cand;
    end
  end
`else
  localparam int unused_stab = STABLE_FLDS;
  assign reach = 1'b1;
`endif

  assign commit = eval & reach & (cand != mode);

  // The first mode acquired after reset is not reported as a change
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      field_id   <= 1'b0;
      lines_o    <= '0;
      mode       <= MODE_RST;
      locked     <= 1'b0;
      mode_chg_o <= 1'b0;
    end else begin
      if (eval) begin
        field_id <= neg_h;
        lines_o  <= lcnt;
      end
      if (eval && reach) locked <= 1'b1;
      if (commit) mode <= cand;
      mode_chg_o <= commit & locked;
    end
  end

  always_comb begin
    vinfo_o              = '0;
    vinfo_o[VINFO_VDATA] = vdata;
    vinfo_o[VINFO_PAL]   = mode.pal;
    vinfo_o[VINFO_480I]  = mode.i480;
  end

endmodule
